// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO_W  = 8;

  // Request payload presented by either requester.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Misaligned byte address, or bits above the word-address range set.
  function automatic logic addr_bad(input logic [DATA_W-1:0] addr,
                                    input int unsigned       addr_w);
    logic [DATA_W-1:0] hi;
    hi = addr >> (addr_w + 32'd2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port that did not win last.
module rr_arb2 (
  input  logic req_c,
  input  logic req_d,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req_c | req_d;
    winner = (req_c & req_d) ? ~last : req_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU fetch/load-store port and the loader/DMA port onto one
// single-port memory with wait states, a response timeout and a CPU stall.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdy,
  output logic              grant
);

  state_e state_q, state_d;

  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_err_q, cpu_err_d;
  logic              dma_ack_q, dma_ack_d;
  logic              dma_err_q, dma_err_d;

  logic arb_valid;
  logic arb_winner;
  req_t cpu_pl;
  req_t dma_pl;
  req_t sel_pl;
  logic sel_bad;

  rr_arb2 u_rr (
    .req_c  (cpu_req),
    .req_d  (dma_req),
    .last   (last_grant_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Winner's payload and its address check, used only in IDLE.
  always_comb begin
    cpu_pl  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    dma_pl  = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    sel_pl  = (arb_winner == PORT_DMA) ? dma_pl : cpu_pl;
    sel_bad = addr_bad(sel_pl.addr, ADDR_W);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_ack_d    = 1'b0;
    cpu_err_d    = 1'b0;
    dma_ack_d    = 1'b0;
    dma_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_winner;
          last_grant_d = arb_winner;
          mem_addr_d   = sel_pl.addr[ADDR_W+1:2];
          mem_wdata_d  = sel_pl.wdata;
          cnt_d        = '0;
          if (sel_bad) begin
            // Rejected without touching memory; complete next cycle.
            state_d = ST_DONE;
            if (arb_winner == PORT_DMA) begin
              dma_ack_d = 1'b1;
              dma_err_d = 1'b1;
            end else begin
              cpu_ack_d = 1'b1;
              cpu_err_d = 1'b1;
            end
          end else begin
            state_d  = ST_ACCESS;
            mem_en_d = 1'b1;
            mem_we_d = sel_pl.we;
          end
        end
      end

      ST_ACCESS: begin
        if (mem_rdy) begin
          state_d  = ST_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (grant_q == PORT_DMA) begin
            dma_ack_d = 1'b1;
            if (!mem_we_q) dma_rdata_d = mem_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = mem_rdata;
          end
        end else if (cnt_q == TMO_W'(TIMEOUT - 32'd1)) begin
          // Memory never answered: give up with an error completion.
          state_d  = ST_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (grant_q == PORT_DMA) begin
            dma_ack_d = 1'b1;
            dma_err_d = 1'b1;
          end else begin
            cpu_ack_d = 1'b1;
            cpu_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_DMA;
      grant_q      <= PORT_CPU;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      dma_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      dma_ack_q    <= dma_ack_d;
      dma_err_q    <= dma_err_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_err   = dma_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant     = grant_q;

  // Holds the controller off PCWr/IRWr until its own completion pulse.
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded random bench for mem_arbiter with a wait-state memory responder.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 10;
  localparam int          TIMEOUT = 15;
  localparam int          NWORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0]       cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0]       cpu_rdata, dma_rdata;
  logic              cpu_ack, cpu_err, cpu_stall, dma_ack, dma_err;
  logic              mem_en, mem_we, mem_rdy, grant;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              err;
    logic              aerr;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] waddr;
    logic              we;
    logic [31:0]       wdata;
    int                lat;
    int                t0;
  } exp_t;

  exp_t        cpu_q[$];
  exp_t        dma_q[$];
  logic        order_q[$];
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] mem_model [NWORDS];
  logic [31:0] last_rd [2];
  logic        ref_last;
  int          cpu_dly, dma_dly;
  int          wcnt;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        mem_en_prev = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    return (i == 2) ? 32'h1234_5678 : 32'(i) * 32'h9E37_79B9 + 32'h0000_5A5A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: answers after a per-port number of wait states.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < NWORDS; i++) mem_model[i] <= init_val(i);
    end else begin
      if (mem_en && !mem_rdy) wcnt <= wcnt + 1;
      else                    wcnt <= 0;
      if (mem_en && mem_rdy && mem_we) mem_model[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdy   = mem_en && (wcnt == (grant ? dma_dly : cpu_dly));
  assign mem_rdata = mem_rdy ? mem_model[mem_addr] : 32'hA5A5_A5A5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_val(i);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    ref_last   = 1'b1;
  endtask

  task automatic check_access();
    exp_t h;
    if ((grant && dma_q.size() == 0) || (!grant && cpu_q.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_access: grant=%0d addr=%h", grant, mem_addr);
    end else begin
      h = grant ? dma_q[0] : cpu_q[0];
      chk("access_on_bad_addr", 32'(h.aerr), 32'd0);
      chk("mem_addr", 32'(mem_addr), 32'(h.waddr));
      chk("mem_we", 32'(mem_we), 32'(h.we));
      if (h.we) chk("mem_wdata", mem_wdata, h.wdata);
    end
  endtask

  task automatic check_ack(input logic p);
    exp_t h;
    logic o;
    if ((p && dma_q.size() == 0) || (!p && cpu_q.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack: port=%0d cycle=%0d", p, cyc);
    end else begin
      h = p ? dma_q.pop_front() : cpu_q.pop_front();
      chk("ack_grant", 32'(grant), 32'(p));
      chk(p ? "dma_err" : "cpu_err", 32'(p ? dma_err : cpu_err), 32'(h.err));
      chk(p ? "dma_rdata" : "cpu_rdata", p ? dma_rdata : cpu_rdata, h.rdata);
      if (h.lat >= 0) chk("latency", 32'(cyc - h.t0), 32'(h.lat));
      if (!p) chk("cpu_stall_at_ack", 32'(cpu_stall), 32'd0);
      if (order_q.size() > 0) begin
        o = order_q.pop_front();
        chk("rr_order", 32'(p), 32'(o));
      end
      ref_last = p;
    end
  endtask

  // Monitor: protocol invariants and scoreboard pops, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("we_outside_access", 32'(mem_we & ~mem_en), 32'd0);
      if (mem_en && !mem_en_prev) check_access();
      if (cpu_ack) check_ack(1'b0);
      if (dma_ack) check_ack(1'b1);
    end
    mem_en_prev = mem_en;
  end

  // Build the expectation from the address rules and the reference memory, then drive.
  task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input int ofs);
    exp_t e;
    logic tmo;
    int   widx;
    e.aerr  = (addr % 4 != 0) || (addr >= 32'(4 * NWORDS));
    tmo     = !e.aerr && (delay >= TIMEOUT);
    e.err   = e.aerr || tmo;
    widx    = int'(addr / 4) % NWORDS;
    e.waddr = ADDR_W'(widx);
    e.we    = we;
    e.wdata = wdata;
    if (!e.err && !we) last_rd[port] = ref_mem[widx];
    if (!e.err && we)  ref_mem[widx] = wdata;
    e.rdata = last_rd[port];
    e.lat   = (ofs < 0) ? -1 : ofs + (e.aerr ? 1 : (tmo ? TIMEOUT + 1 : delay + 2));
    e.t0    = cyc;
    if (port) begin
      dma_dly = delay; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      dma_q.push_back(e);
      dma_req = 1'b1;
    end else begin
      cpu_dly = delay; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      cpu_q.push_back(e);
      cpu_req = 1'b1;
    end
  endtask

  task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int delay, input int ofs);
    bit got;
    got = 1'b0;
    issue(port, we, addr, wdata, delay, ofs);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (!port && ofs >= 0 && i == 0) chk("cpu_stall_waiting", 32'(cpu_stall), 32'd1);
      if ((port ? dma_ack : cpu_ack) == 1'b1) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_wait: port=%0d addr=%h no ack within 100 cycles", port, addr);
    end
    @(posedge clk);
    #1;
    if (port) dma_req = 1'b0;
    else      cpu_req = 1'b0;
  endtask

  // Both ports held: strict alternation starting with the port not granted last.
  task automatic contend(input int n);
    logic first;
    first = ~ref_last;
    for (int i = 0; i < 2 * n; i++) order_q.push_back(first ^ logic'(i % 2));
    fork
      begin
        for (int i = 0; i < n; i++)
          txn(1'b0, 1'b0, 32'(32'h40 + 4 * i), 32'd0, (i == 0) ? 0 : i % 3,
              (i == 0) ? ((first == 1'b0) ? 0 : 3) : -1);
      end
      begin
        for (int k = 0; k < n; k++)
          txn(1'b1, 1'b0, 32'(32'h800 + 4 * k), 32'd0, (k == 0) ? 0 : (k + 1) % 3,
              (k == 0) ? ((first == 1'b1) ? 0 : 3) : -1);
      end
    join
  endtask

  function automatic logic [31:0] rnd_addr(input int lo_w, input int hi_w);
    int r;
    int w;
    r = $urandom_range(0, 9);
    w = $urandom_range(hi_w, lo_w);
    if (r == 0) return 32'(w * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'h0000_1000 | $urandom;
    return 32'(w * 4);
  endfunction

  function automatic int rnd_delay();
    int r;
    r = $urandom_range(0, 15);
    if (r == 15) return 255;
    if (r == 14) return TIMEOUT - 1;
    return r % 4;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_dly = 0; dma_dly = 0;
    reset_model();
    repeat (2) @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dma_rdata", dma_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    txn(1'b0, 1'b0, 32'h0000_0008, 32'd0, 0, 0);
    txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3, 0);
    txn(1'b0, 1'b0, 32'h0000_0100, 32'd0, 1, 0);
    txn(1'b0, 1'b0, 32'h0000_0006, 32'd0, 0, 0);
    txn(1'b0, 1'b0, 32'h0000_1000, 32'd0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0003, 32'd0, 0, 0);
    txn(1'b0, 1'b0, 32'h0000_0FFC, 32'd0, 0, 0);
    txn(1'b0, 1'b0, 32'h0000_0020, 32'd0, 255, 0);
    txn(1'b0, 1'b0, 32'h0000_0024, 32'd0, 0, 0);
    txn(1'b1, 1'b0, 32'h0000_0028, 32'd0, TIMEOUT - 1, 0);
    contend(2);

    for (int n = 0; n < 40; n++)
      txn(1'(($urandom >> 3) & 1), 1'($urandom & 1), rnd_addr(0, NWORDS - 1),
          $urandom, rnd_delay(), 0);

    fork
      begin
        for (int n = 0; n < 12; n++)
          txn(1'b0, 1'($urandom & 1), rnd_addr(0, NWORDS / 2 - 1), $urandom, rnd_delay(), -1);
      end
      begin
        for (int m = 0; m < 12; m++)
          txn(1'b1, 1'($urandom & 1), rnd_addr(NWORDS / 2, NWORDS - 1), $urandom, rnd_delay(), -1);
      end
    join

    // Reset in the middle of a stalled access: the transfer is simply dropped.
    issue(1'b0, 1'b0, 32'h0000_0040, 32'd0, 255, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_mem_en", 32'(mem_en), 32'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mid_dma_ack", 32'(dma_ack), 32'd0);
    cpu_q.delete();
    dma_q.delete();
    order_q.delete();
    reset_model();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("post_rst_grant", 32'(grant), 32'd0);
    contend(2);

    repeat (4) @(posedge clk);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    chk("dma_queue_drained", 32'(dma_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
